cpu_control: RTL and testbench



---
 rtl/cpu_control_pkg.sv | 32 +++
 rtl/cpu_control_instr_decoder.sv | 28 ++
 rtl/cpu_control.sv | 178 +++++++++++++++++
 tb/tb_cpu_control.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_control_pkg.sv
// Shared constants and state encoding for the cpu_control instruction sequencer.
package cpu_control_pkg;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_IMM  = 2'b10;
  localparam logic [1:0] OP_REG  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_MVN  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_NOT = 2'b11;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM8  = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_COMPUTE   = 3'd5,
    S_WRITE_REG = 3'd6,
    S_HALT      = 3'd7
  } state_t;

endpackage

// File: rtl/cpu_control_instr_decoder.sv
// Combinational field extraction and sign extension of the 16-bit instruction register.
module instr_decoder
  import cpu_control_pkg::*;
#(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic [IW-1:0] i_ir,
  output logic [2:0]    o_opcode,
  output logic [1:0]    o_op,
  output logic [RW-1:0] o_rn,
  output logic [RW-1:0] o_rd,
  output logic [1:0]    o_sh,
  output logic [RW-1:0] o_rm,
  output logic [IW-1:0] o_sximm8,
  output logic [IW-1:0] o_sximm5
);

  assign o_opcode = i_ir[15:13];
  assign o_op     = i_ir[12:11];
  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm8 = {{(IW-8){i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{(IW-5){i_ir[4]}}, i_ir[4:0]};

endmodule

// File: rtl/cpu_control.sv
// Instruction register plus Moore FSM sequencing datapath strobes for MOV/ADD/CMP/AND/MVN.
// Define CPU_CONTROL_ILLEGAL_TRAP_EN to park undefined instructions in Halt with illegal=1.
module cpu_control
  import cpu_control_pkg::*;
#(
  parameter int IW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [IW-1:0] in,
  output logic [RW-1:0] readnum,
  output logic [RW-1:0] writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          asel,
  output logic          bsel,
  output logic          loadc,
  output logic          loads,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [IW-1:0] sximm8,
  output logic [IW-1:0] sximm5,
  output logic          w,
  output logic          illegal
);

  state_t        r_state;
  state_t        w_next_state;
  state_t        w_bad_dest;
  logic [IW-1:0] r_ir;
  logic [2:0]    w_opcode;
  logic [1:0]    w_op;
  logic [RW-1:0] w_rn;
  logic [RW-1:0] w_rd;
  logic [RW-1:0] w_rm;
  logic [1:0]    w_sh;
  logic          w_is_cmp;

  instr_decoder #(.IW(IW), .RW(RW)) u_dec (
    .i_ir     (r_ir),
    .o_opcode (w_opcode),
    .o_op     (w_op),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_sh     (w_sh),
    .o_rm     (w_rm),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5)
  );

  assign w_is_cmp = (w_opcode == OPC_ALU) && (w_op == OP_CMP);

`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
  assign w_bad_dest = S_HALT;
`else
  assign w_bad_dest = S_WAIT;
`endif

  // State register and IR; IR only accepts a new word while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_WAIT) && load) begin
        r_ir <= in;
      end
    end
  end

  // Next-state selection.
  always_comb begin
    w_next_state = S_WAIT;
    case (r_state)
      S_WAIT: begin
        if (s) w_next_state = S_DECODE;
        else   w_next_state = S_WAIT;
      end
      S_DECODE: begin
        if ((w_opcode == OPC_MOV) && (w_op == OP_IMM))      w_next_state = S_WRITE_IMM;
        else if ((w_opcode == OPC_MOV) && (w_op == OP_REG)) w_next_state = S_GET_B;
        else if ((w_opcode == OPC_ALU) && (w_op == OP_MVN)) w_next_state = S_GET_B;
        else if (w_opcode == OPC_ALU)                       w_next_state = S_GET_A;
        else                                                w_next_state = w_bad_dest;
      end
      S_WRITE_IMM: w_next_state = S_WAIT;
      S_GET_A:     w_next_state = S_GET_B;
      S_GET_B:     w_next_state = S_COMPUTE;
      S_COMPUTE: begin
        if (w_is_cmp) w_next_state = S_WAIT;
        else          w_next_state = S_WRITE_REG;
      end
      S_WRITE_REG: w_next_state = S_WAIT;
      S_HALT:      w_next_state = w_bad_dest;
      default:     w_next_state = S_WAIT;
    endcase
  end

  // Moore strobe decode; everything idles at zero outside its owning state.
  always_comb begin
    readnum  = '0;
    writenum = '0;
    write    = 1'b0;
    vsel     = VSEL_MDATA;
    loada    = 1'b0;
    loadb    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    shift    = 2'b00;
    ALUop    = ALU_ADD;
    case (r_state)
      S_WRITE_IMM: begin
        writenum = w_rn;
        vsel     = VSEL_IMM8;
        write    = 1'b1;
      end
      S_GET_A: begin
        readnum = w_rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = w_rm;
        loadb   = 1'b1;
      end
      S_COMPUTE: begin
        shift = w_sh;
        loadc = ~w_is_cmp;
        loads = w_is_cmp;
        if (w_opcode == OPC_MOV) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else if (w_op == OP_MVN) begin
          asel  = 1'b1;
          ALUop = ALU_NOT;
        end else begin
          asel  = 1'b0;
          ALUop = w_op;
        end
      end
      S_WRITE_REG: begin
        writenum = w_rd;
        vsel     = VSEL_C;
        write    = 1'b1;
      end
      default: begin
        readnum = '0;
      end
    endcase
  end

  assign w = (r_state == S_WAIT);

`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
  logic r_illegal;

  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_illegal <= 1'b0;
    end else if (w_next_state == S_HALT) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control.sv
// Randomized self-checking bench for cpu_control against a per-instruction cycle-table model.
module tb_cpu_control;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads, w, illegal;
  logic [1:0]  vsel, shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int n_checks = 0;
  int n_pass   = 0;

  typedef logic [20:0] vec_t;
  vec_t exp_q[$];

  cpu_control dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc),
    .loads(loads), .shift(shift), .ALUop(ALUop), .sximm8(sximm8),
    .sximm5(sximm5), .w(w), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic vec_t obs_vec();
    return {w, write, writenum, readnum, vsel, loada, loadb, asel, bsel,
            loadc, loads, shift, ALUop, illegal};
  endfunction

  function automatic vec_t ev(bit iw, bit wr, logic [2:0] wn, logic [2:0] rn,
                              logic [1:0] vs, bit la, bit lb, bit as, bit lc,
                              bit ls, logic [1:0] sh, logic [1:0] alu, bit il);
    return {iw, wr, wn, rn, vs, la, lb, as, 1'b0, lc, ls, sh, alu, il};
  endfunction

  function automatic vec_t idle_v();
    return ev(1, 0, 3'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
  endfunction

  function automatic vec_t busy0_v();
    return ev(0, 0, 3'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0);
  endfunction

  // Expected per-cycle outputs after the s edge, straight from the instruction table.
  task automatic model(input logic [15:0] ir, output bit halted);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh, alu;
    bit is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn, as;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8];
    rd = ir[7:5];    sh = ir[4:3];   rm = ir[2:0];
    is_mov_imm = (opc == 3'b110) && (op == 2'b10);
    is_mov_reg = (opc == 3'b110) && (op == 2'b00);
    is_alu     = (opc == 3'b101);
    is_cmp     = is_alu && (op == 2'b01);
    is_mvn     = is_alu && (op == 2'b11);
    halted = 0;
    exp_q.delete();
    exp_q.push_back(busy0_v());
    if (is_mov_imm) begin
      exp_q.push_back(ev(0, 1, rn, 3'd0, 2'b01, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    end else if (is_mov_reg || is_alu) begin
      if (is_alu && !is_mvn)
        exp_q.push_back(ev(0, 0, 3'd0, rn, 2'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0));
      exp_q.push_back(ev(0, 0, 3'd0, rm, 2'd0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 0));
      as  = is_mov_reg || is_mvn;
      alu = is_mov_reg ? 2'b00 : op;
      exp_q.push_back(ev(0, 0, 3'd0, 3'd0, 2'd0, 0, 0, as, !is_cmp, is_cmp, sh, alu, 0));
      if (!is_cmp)
        exp_q.push_back(ev(0, 1, rd, 3'd0, 2'b11, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    end else begin
`ifdef CPU_CONTROL_ILLEGAL_TRAP_EN
      for (int k = 0; k < 4; k++)
        exp_q.push_back(ev(0, 0, 3'd0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 1));
      halted = 1;
`endif
    end
    if (!halted) exp_q.push_back(idle_v());
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; s = 1'b0; load = 1'b0;
    check_val({tag, "_idle"}, 32'(obs_vec()), 32'(idle_v()));
    check_val({tag, "_ir"}, 32'(dut.r_ir), 32'h0);
  endtask

  // Called #1 after an edge with the FSM idle in Wait.
  task automatic run_instr(input logic [15:0] word, input bit same_edge);
    bit halted;
    vec_t e;
    logic [15:0] x8, x5;
    check_val("pre_wait", 32'(obs_vec()), 32'(idle_v()));
    if (!same_edge) begin
      load = 1'b1; in = word; s = 1'b0;
      @(posedge clk); #1;
      load = 1'b0;
      check_val("load_only_wait", 32'(obs_vec()), 32'(idle_v()));
    end
    load = same_edge; in = word; s = 1'b1;
    @(posedge clk); #1;
    s = 1'b0; load = 1'b0;
    x8 = 16'(signed'(word[7:0]));
    x5 = 16'(signed'(word[4:0]));
    check_val("sximm8", 32'(sximm8), 32'(x8));
    check_val("sximm5", 32'(sximm5), 32'(x5));
    model(word, halted);
    forever begin
      e = exp_q.pop_front();
      check_val($sformatf("cyc_%h", word), 32'(obs_vec()), 32'(e));
      if (exp_q.size() == 0) break;
      s = 1'($urandom); load = 1'($urandom); in = 16'($urandom);
      @(posedge clk); #1;
    end
    s = 1'b0; load = 1'b0;
    check_val("ir_kept", 32'(dut.r_ir), 32'(word));
    if (halted) do_reset("halt_rst");
  endtask

  initial begin
    logic [15:0] word;
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("reset_idle", 32'(obs_vec()), 32'(idle_v()));
    check_val("reset_ir", 32'(dut.r_ir), 32'h0);

    run_instr(16'hD007, 1'b0);
    run_instr(16'hD1FE, 1'b1);
    run_instr(16'hA148, 1'b0);
    run_instr(16'hA900, 1'b1);
    run_instr(16'hB867, 1'b0);

    // ADD with a dropped load in GetA, then reset in Compute.
    load = 1'b1; s = 1'b1; in = 16'hA148;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    check_val("mid_getA", 32'(obs_vec()),
              32'(ev(0, 0, 3'd0, 3'd1, 2'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 0)));
    load = 1'b1; in = 16'hD007;
    @(posedge clk); #1;
    load = 1'b0;
    check_val("mid_drop_ir", 32'(dut.r_ir), 32'hA148);
    @(posedge clk); #1;
    check_val("mid_compute", 32'(obs_vec()),
              32'(ev(0, 0, 3'd0, 3'd0, 2'd0, 0, 0, 0, 1, 0, 2'b01, 2'b00, 0)));
    do_reset("mid_rst");

    run_instr(16'hE000, 1'b1);

    for (int i = 0; i < 150; i++) begin
      word = 16'($urandom);
      case ($urandom_range(0, 3))
        0: word[15:11] = 5'b11010;
        1: word[15:11] = 5'b11000;
        2: word[15:13] = 3'b101;
        default: word = word;
      endcase
      run_instr(word, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
